// File: rtl/xsim_mem_arb_pkg.sv
// xsim_mem_arb_pkg: shared FSM and access-kind enums plus data widths for xsim_mem_arbiter.
package xsim_mem_arb_pkg;
    localparam int W32 = 32;
    localparam int W64 = 64;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;
    typedef enum logic [1:0] {RD32, RD64, WR32, WR64} kind_e;
    function automatic kind_e kind_of(input logic write, input logic wide);
        return kind_e'({write, wide});
    endfunction
endpackage

// File: rtl/xsim_mem_arbiter_if.sv
// xsim_mem_arbiter_if: requester and simulated-memory port bundle; slave = arbiter side, master = environment side.
interface xsim_mem_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import xsim_mem_arb_pkg::*;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ-1:0]     req_write;
    logic [NUM_REQ-1:0]     req_wide;
    logic [NUM_REQ*W32-1:0] req_handle;
    logic [NUM_REQ*W32-1:0] req_addr;
    logic [NUM_REQ*W64-1:0] req_wdata;
    logic [NUM_REQ-1:0]     resp_valid;
    logic [NUM_REQ-1:0]     resp_ready;
    logic [W64-1:0]         resp_rdata;
    logic                   mem_en_read32;
    logic                   mem_en_read64;
    logic                   mem_en_write32;
    logic                   mem_en_write64;
    logic [W32-1:0]         mem_handle;
    logic [W32-1:0]         mem_addr;
    logic [W64-1:0]         mem_wdata;
    logic [W32-1:0]         mem_rdata32;
    logic [W64-1:0]         mem_rdata64;
    modport slave (
        input  req_valid, req_write, req_wide, req_handle, req_addr, req_wdata, resp_ready,
               mem_rdata32, mem_rdata64,
        output req_ready, resp_valid, resp_rdata, mem_en_read32, mem_en_read64,
               mem_en_write32, mem_en_write64, mem_handle, mem_addr, mem_wdata
    );
    modport master (
        output req_valid, req_write, req_wide, req_handle, req_addr, req_wdata, resp_ready,
               mem_rdata32, mem_rdata64,
        input  req_ready, resp_valid, resp_rdata, mem_en_read32, mem_en_read64,
               mem_en_write32, mem_en_write64, mem_handle, mem_addr, mem_wdata
    );
endinterface

// File: rtl/xsim_rr_arbiter.sv
// xsim_rr_arbiter: combinational round-robin pick; the search starts one past i_last and wraps.
module xsim_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_last,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IW-1:0]      o_idx,
    output logic               o_any
);
    logic [IW-1:0] w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_j = IW'((int'(i_last) + k) % NUM_REQ);
            if (!o_any && i_req[w_j]) begin
                o_any = 1'b1;
                o_idx = w_j;
            end
        end
        o_gnt[o_idx] = o_any;
    end
endmodule

// File: rtl/xsim_mem_arbiter.sv
// xsim_mem_arbiter: round-robin arbiter serialising NUM_REQ requesters onto one simulated-memory port.
// Defining XSIM_MEM_ARB_STATS_EN adds per-requester accepted-transaction counters on grant_count.
module xsim_mem_arbiter
    import xsim_mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input logic               CLK,
    input logic               RST,
    xsim_mem_arbiter_if.slave bus
`ifdef XSIM_MEM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*W32-1:0] grant_count
`endif
);
    localparam int IW = $clog2(NUM_REQ);

    state_e             r_state, w_next;
    kind_e              r_kind;
    logic [IW-1:0]      r_last, r_sel, w_idx;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_any, w_accept;
    logic [W32-1:0]     r_handle, r_addr;
    logic [W64-1:0]     r_wdata, r_rdata;

    xsim_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
        .i_req  (bus.req_valid),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    // Gated by RST so no grant is offered while reset is held.
    assign w_accept = (r_state == IDLE) && w_any && !RST;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? ISSUE : IDLE;
            ISSUE:   w_next = (r_kind inside {WR32, WR64}) ? RESP : CAPTURE;
            CAPTURE: w_next = RESP;
            RESP:    w_next = bus.resp_ready[r_sel] ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
        bus.req_ready          = w_accept ? w_gnt : '0;
        bus.resp_valid         = '0;
        bus.resp_valid[r_sel]  = (r_state == RESP);
        bus.mem_en_read32      = (r_state == ISSUE) && (r_kind == RD32);
        bus.mem_en_read64      = (r_state == ISSUE) && (r_kind == RD64);
        bus.mem_en_write32     = (r_state == ISSUE) && (r_kind == WR32);
        bus.mem_en_write64     = (r_state == ISSUE) && (r_kind == WR64);
        bus.mem_handle         = r_handle;
        bus.mem_addr           = r_addr;
        bus.mem_wdata          = r_wdata;
        bus.resp_rdata         = r_rdata;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_last   <= IW'(NUM_REQ - 1);
            r_sel    <= '0;
            r_kind   <= RD32;
            r_handle <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_last   <= w_idx;
                r_sel    <= w_idx;
                r_kind   <= kind_of(bus.req_write[w_idx], bus.req_wide[w_idx]);
                r_handle <= bus.req_handle[w_idx*W32 +: W32];
                r_addr   <= bus.req_addr[w_idx*W32 +: W32];
                r_wdata  <= bus.req_wdata[w_idx*W64 +: W64];
                r_rdata  <= '0;
            end
            if (r_state == CAPTURE)
                r_rdata <= (r_kind == RD64) ? bus.mem_rdata64 : {{W32{1'b0}}, bus.mem_rdata32};
        end
    end

`ifdef XSIM_MEM_ARB_STATS_EN
    logic [W32-1:0] r_cnt [NUM_REQ];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_cnt <= '{default: '0};
        else if (w_accept)
            r_cnt[w_idx] <= r_cnt[w_idx] + 1'b1;
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_count[g*W32 +: W32] = r_cnt[g];
    end
`endif
endmodule

// File: tb/tb_xsim_mem_arbiter.sv
// tb_xsim_mem_arbiter: directed and randomized checks of xsim_mem_arbiter against a transaction-level model.
// Stats checks compile only when XSIM_MEM_ARB_STATS_EN is defined.
module tb_xsim_mem_arbiter;
    import xsim_mem_arb_pkg::*;
    localparam int N = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    xsim_mem_arbiter_if #(.NUM_REQ(N)) bus ();
`ifdef XSIM_MEM_ARB_STATS_EN
    logic [N*32-1:0] grant_count;
`endif

    xsim_mem_arbiter #(.NUM_REQ(N)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
`ifdef XSIM_MEM_ARB_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory contents: mem is what the responder serves, ref_mem is the model's own copy.
    logic [63:0] mem     [logic [63:0]];
    logic [63:0] ref_mem [logic [63:0]];

    function automatic logic [63:0] init_val(input logic [63:0] k);
        return {~k[31:0], k[63:32] ^ k[31:0] ^ 32'h5A5A_0000};
    endfunction
    function automatic logic [63:0] mem_get(input logic [63:0] k);
        return mem.exists(k) ? mem[k] : init_val(k);
    endfunction
    function automatic logic [63:0] ref_get(input logic [63:0] k);
        return ref_mem.exists(k) ? ref_mem[k] : init_val(k);
    endfunction

    // Read data is valid only in the cycle after the strobe; otherwise the lines carry noise.
    bit pend = 1'b0;
    always @(negedge CLK) begin
        logic [63:0] k, v;
        k = {bus.mem_handle, bus.mem_addr};
        v = mem_get(k);
        if (!RST && bus.mem_en_write32) mem[k] = {v[63:32], bus.mem_wdata[31:0]};
        if (!RST && bus.mem_en_write64) mem[k] = bus.mem_wdata;
        if (!RST && (bus.mem_en_read32 || bus.mem_en_read64)) begin
            bus.mem_rdata32 = bus.mem_en_read32 ? v[31:0] : $urandom;
            bus.mem_rdata64 = bus.mem_en_read64 ? v : {$urandom, $urandom};
            pend = 1'b1;
        end else if (pend && !RST) begin
            pend = 1'b0;
        end else begin
            pend = 1'b0;
            bus.mem_rdata32 = $urandom;
            bus.mem_rdata64 = {$urandom, $urandom};
        end
    end

    bit          m_busy = 1'b0;
    int          m_age, m_id;
    int          m_last = N - 1;
    bit          m_write, m_wide;
    logic [31:0] m_h, m_a;
    logic [63:0] m_d, m_data;
    int          n_acc = 0, n_hs = 0, n_w64 = 0, acc_c = 0;
    bit          seen_rv = 1'b0;
    int          grant_log[$], lat_log[$];
    logic [63:0] rdata_log[$];

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction
    function automatic int idx_of(input logic [N-1:0] oh);
        for (int i = 0; i < N; i++)
            if (oh[i]) return i;
        return -1;
    endfunction

    // Model: a transaction is accepted, strobes one cycle later, and answers 3 (read) or 2 (write) cycles after accept.
    always @(negedge CLK) begin
        logic [N-1:0] e_ready, e_rv;
        logic [3:0]   e_str, a_str;
        logic [63:0]  k, v;
        int           w;
        a_str = {bus.mem_en_write64, bus.mem_en_write32, bus.mem_en_read64, bus.mem_en_read32};
        if (bus.req_ready != 0) begin
            n_acc++;
            grant_log.push_back(idx_of(bus.req_ready));
            acc_c = cyc;
            seen_rv = 1'b0;
        end
        if (bus.resp_valid != 0 && !seen_rv) begin
            seen_rv = 1'b1;
            lat_log.push_back(int'(cyc) - acc_c);
        end
        if ((bus.resp_valid & bus.resp_ready) != 0) begin
            n_hs++;
            rdata_log.push_back(bus.resp_rdata);
        end
        if (bus.mem_en_write64) n_w64++;
        if (RST) begin
            chk("reset_outputs", {bus.req_ready, bus.resp_valid, a_str, |bus.mem_handle, |bus.mem_addr,
                                  |bus.mem_wdata, |bus.resp_rdata}, 64'h0);
            m_busy = 1'b0;
            m_last = N - 1;
        end else begin
            e_ready = '0;
            e_rv    = '0;
            e_str   = '0;
            w = rr_pick(bus.req_valid, m_last);
            if (!m_busy && w >= 0) e_ready[w] = 1'b1;
            if (m_busy) begin
                m_age++;
                if (m_age == 1) begin
                    e_str[{m_write, m_wide}] = 1'b1;
                    chk("issue_handle", bus.mem_handle, m_h);
                    chk("issue_addr", bus.mem_addr, m_a);
                    chk("issue_wdata", bus.mem_wdata, m_d);
                    k = {m_h, m_a};
                    v = ref_get(k);
                    if (m_write) ref_mem[k] = m_wide ? m_d : {v[63:32], m_d[31:0]};
                    m_data = m_write ? 64'h0 : (m_wide ? v : {32'h0, v[31:0]});
                end
                if (m_age >= (m_write ? 2 : 3)) begin
                    e_rv[m_id] = 1'b1;
                    chk("resp_rdata", bus.resp_rdata, m_data);
                end
            end
            chk("req_ready", bus.req_ready, e_ready);
            chk("resp_valid", bus.resp_valid, e_rv);
            chk("strobes", a_str, e_str);
            if (e_ready != 0) begin
                m_busy  = 1'b1;
                m_age   = 0;
                m_last  = w;
                m_id    = w;
                m_write = bus.req_write[w];
                m_wide  = bus.req_wide[w];
                m_h     = bus.req_handle[w*32 +: 32];
                m_a     = bus.req_addr[w*32 +: 32];
                m_d     = bus.req_wdata[w*64 +: 64];
            end else if (e_rv != 0 && bus.resp_ready[m_id]) begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input bit wr, input bit wd, input logic [31:0] h, input logic [31:0] a,
                           input logic [63:0] d);
        bus.req_write[i]          = wr;
        bus.req_wide[i]           = wd;
        bus.req_handle[i*32 +: 32] = h;
        bus.req_addr[i*32 +: 32]   = a;
        bus.req_wdata[i*64 +: 64]  = d;
    endtask

    task automatic wait_for(input string nm, input int tgt, input bit hs);
        int t = 0;
        while (((hs ? n_hs : n_acc) < tgt) && t < 200) begin
            tick();
            t++;
        end
        chk({nm, "_timeout"}, 64'(t < 200), 64'h1);
    endtask

    initial begin
        int a0, h0, w0, l0, r0, b0;
        int ord[5] = '{0, 1, 2, 3, 0};
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0);
        RST = 1'b1;
        repeat (3) tick();
        chk("rst_rdata", bus.resp_rdata, 64'h0);
        chk("rst_ready", bus.req_ready, 64'h0);
        RST = 1'b0;

        // All four reading continuously: grants rotate starting at requester 0.
        b0 = grant_log.size(); l0 = lat_log.size(); a0 = n_acc; h0 = n_hs;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 32'h10 + i, 32'h200 + 8 * i, 64'h0);
        bus.resp_ready = '1;
        bus.req_valid  = '1;
        wait_for("rr_acc", a0 + 5, 1'b0);
        bus.req_valid = '0;
        wait_for("rr_hs", h0 + 5, 1'b1);
        for (int j = 0; j < 5; j++) begin
            chk("rr_order", 64'(grant_log[b0 + j]), 64'(ord[j]));
            chk("rd_latency", 64'(lat_log[l0 + j]), 64'd3);
        end

        // Write64 then read64 of the same location from requester 2.
        a0 = n_acc; h0 = n_hs; w0 = n_w64; r0 = rdata_log.size(); l0 = lat_log.size();
        set_req(2, 1'b1, 1'b1, 32'h5, 32'h100, 64'hDEADBEEF_CAFEF00D);
        bus.req_valid = 4'b0100;
        wait_for("wr_acc", a0 + 1, 1'b0);
        set_req(2, 1'b0, 1'b1, 32'h5, 32'h100, 64'h0);
        wait_for("rd_acc", a0 + 2, 1'b0);
        bus.req_valid = '0;
        wait_for("wr_rd_hs", h0 + 2, 1'b1);
        chk("w64_strobe_cycles", 64'(n_w64 - w0), 64'd1);
        chk("wr_latency", 64'(lat_log[l0]), 64'd2);
        chk("write_ack_rdata", rdata_log[r0], 64'h0);
        chk("read64_data", rdata_log[r0 + 1], 64'hDEADBEEF_CAFEF00D);

        // Read32 must zero-extend, ignoring the upper half of the stored word.
        mem[{32'h7, 32'h40}]     = 64'hFFFF0000_12345678;
        ref_mem[{32'h7, 32'h40}] = 64'hFFFF0000_12345678;
        a0 = n_acc; h0 = n_hs;
        set_req(1, 1'b0, 1'b0, 32'h7, 32'h40, 64'h0);
        bus.req_valid = 4'b0010;
        wait_for("r32_acc", a0 + 1, 1'b0);
        bus.req_valid = '0;
        wait_for("r32_hs", h0 + 1, 1'b1);
        chk("read32_zext", rdata_log[$], 64'h00000000_12345678);

        // Response held off for 10 cycles while others request and assert resp_ready.
        a0 = n_acc; h0 = n_hs;
        set_req(3, 1'b0, 1'b1, 32'h5, 32'h100, 64'h0);
        bus.resp_ready = '0;
        bus.req_valid  = 4'b1000;
        wait_for("hold_acc", a0 + 1, 1'b0);
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 32'h1, 32'h8, 64'h0);
        bus.req_valid  = 4'b0111;
        bus.resp_ready = 4'b0111;
        tick();
        tick();
        for (int j = 0; j < 10; j++) begin
            chk("hold_resp_valid", bus.resp_valid, 64'h8);
            chk("hold_rdata", bus.resp_rdata, 64'hDEADBEEF_CAFEF00D);
            chk("hold_ready", bus.req_ready, 64'h0);
            chk("hold_strobes", {bus.mem_en_read32, bus.mem_en_read64, bus.mem_en_write32, bus.mem_en_write64}, 64'h0);
            tick();
        end
        bus.resp_ready = 4'b1000;
        wait_for("hold_hs", h0 + 1, 1'b1);
        bus.req_valid  = '0;
        bus.resp_ready = '1;
        tick();

        // Reset during ISSUE abandons the read; requester 0 wins first afterwards.
        a0 = n_acc; h0 = n_hs;
        set_req(1, 1'b0, 1'b0, 32'h2, 32'h18, 64'h0);
        bus.req_valid = 4'b0010;
        wait_for("rst_acc", a0 + 1, 1'b0);
        RST = 1'b1;
        tick();
        chk("rst_issue_strobes", {bus.mem_en_read32, bus.mem_en_read64, bus.mem_en_write32, bus.mem_en_write64}, 64'h0);
        chk("rst_issue_ready", bus.req_ready, 64'h0);
        chk("rst_issue_resp", bus.resp_valid, 64'h0);
        chk("rst_issue_bus", {bus.mem_handle, bus.mem_addr}, 64'h0);
        RST = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 32'h3, 32'h20 + i, 64'h0);
        a0 = n_acc;
        bus.req_valid = '1;
        wait_for("post_rst_acc", a0 + 1, 1'b0);
        bus.req_valid = '0;
        chk("post_rst_first", 64'(grant_log[$]), 64'd0);
        wait_for("post_rst_hs", h0 + 1, 1'b1);
        chk("abandoned_no_resp", 64'(n_hs - h0), 64'd1);

        // Randomized traffic with occasional reset pulses.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'($urandom), 1'($urandom), 32'($urandom_range(0, 1)),
                        32'h100 + 32'($urandom_range(0, 3)) * 8, {$urandom, $urandom});
            bus.req_valid  = N'($urandom);
            bus.resp_ready = N'($urandom);
            RST = ($urandom_range(0, 199) == 0);
            tick();
        end
        RST = 1'b0;
        bus.req_valid  = '0;
        bus.resp_ready = '1;
        repeat (6) tick();

`ifdef XSIM_MEM_ARB_STATS_EN
        begin
            logic [31:0] c1;
            force dut.r_cnt[0] = 32'hFFFF_FFFF;
            tick();
            release dut.r_cnt[0];
            c1 = grant_count[63:32];
            a0 = n_acc; h0 = n_hs;
            set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 64'h0);
            bus.req_valid = 4'b0001;
            wait_for("stats_acc", a0 + 1, 1'b0);
            bus.req_valid = '0;
            wait_for("stats_hs", h0 + 1, 1'b1);
            chk("stats_wrap", grant_count[31:0], 64'h0);
            chk("stats_other", grant_count[63:32], c1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
        $fatal(1);
    end
endmodule
